// File: rtl/branch_predict_gshare.sv
// branch_predict_gshare
//   Global branch predictor: a pattern history table (PHT) of saturating
//   counters indexed from the fetch PC, either directly (bimodal) or XORed
//   with a non-speculative global history register (gshare). The prediction
//   is combinational in F. Training happens on branches resolved in E. A
//   sequencing FSM writes weakly-not-taken into every entry after reset or
//   flush, so the table array carries no reset flops.
//
//   Optional feature macro: BP_STATS_EN (performance counters).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   pcF               fetch PC
//   predict_takeF     predicted taken for pcF (masked until readyF)
//   PHT_indexF        table index used for pcF, carried down the pipe
//   readyF            table initialised, predictions valid
//   branchE           resolved conditional branch in E
//   PHT_indexE        index captured at fetch for that branch
//   actually_takenE   branch outcome
//   predict_resultE   1 = prediction was correct (stats only)
//   flush_tbl         single-cycle request to re-initialise PHT and GHR
//   lookup_cnt        resolved-branch count (0 without BP_STATS_EN)
//   mispredict_cnt    misprediction count (0 without BP_STATS_EN)

module branch_predict_gshare #(
  parameter int unsigned PHT_INDEX_BITS = 10,
  parameter int unsigned HIST_BITS      = 10,
  parameter int unsigned CTR_BITS       = 2,
  parameter int unsigned INDEX_MODE     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  output logic                      predict_takeF,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  output logic                      readyF,
  input  logic                      branchE,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexE,
  input  logic                      actually_takenE,
  input  logic                      predict_resultE,
  input  logic                      flush_tbl,
  output logic [31:0]               lookup_cnt,
  output logic [31:0]               mispredict_cnt
);

  localparam int unsigned ENTRIES = 1 << PHT_INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                    r_state;
  logic [PHT_INDEX_BITS-1:0] r_ptr;
  logic [HIST_BITS-1:0]      r_ghr;
  logic                      r_ready;
  logic [CTR_BITS-1:0]       r_pht [ENTRIES];

  logic [PHT_INDEX_BITS-1:0] w_pc_hash;
  logic [PHT_INDEX_BITS-1:0] w_ghr_ext;
  logic [CTR_BITS-1:0]       w_ctrF;
  logic [CTR_BITS-1:0]       w_ctrE;
  logic [CTR_BITS-1:0]       w_ctr_next;
  logic [HIST_BITS:0]        w_ghr_shift;
  logic                      w_train;
  logic                      w_init_wr;

  // ---------------------------------------------------------------- lookup
  assign w_pc_hash  = pcF[PHT_INDEX_BITS+1:2];
  assign w_ghr_ext  = PHT_INDEX_BITS'(r_ghr);
  assign PHT_indexF = (INDEX_MODE == 0) ? w_pc_hash : (w_pc_hash ^ w_ghr_ext);

  // Read is asynchronous, so a same-cycle update to this entry is seen only
  // after the edge.
  assign w_ctrF        = r_pht[PHT_indexF];
  assign predict_takeF = r_ready & w_ctrF[CTR_BITS-1];
  assign readyF        = r_ready;

  // ---------------------------------------------------------------- training
  // Flush takes priority over a coincident branch resolution.
  assign w_train   = (r_state == S_READY) && branchE && !flush_tbl;
  assign w_init_wr = (r_state == S_INIT) && !flush_tbl;
  assign w_ctrE    = r_pht[PHT_indexE];

  always_comb begin
    w_ctr_next = w_ctrE;
    if (actually_takenE) begin
      if (w_ctrE != CTR_MAX) w_ctr_next = w_ctrE + 1'b1;
    end else begin
      if (w_ctrE != CTR_MIN) w_ctr_next = w_ctrE - 1'b1;
    end
  end

  // One bit wider than the GHR so the shift also works for HIST_BITS == 1.
  assign w_ghr_shift = {r_ghr, actually_takenE};

  // ---------------------------------------------------------------- table
  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_pht[r_ptr] <= CTR_WNT;
    end else if (w_train) begin
      r_pht[PHT_indexE] <= w_ctr_next;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_ghr   <= '0;
      r_ready <= 1'b0;
    end else if (flush_tbl) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_ghr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == '1) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end
        end
        S_READY: begin
          if (branchE) r_ghr <= w_ghr_shift[HIST_BITS-1:0];
        end
        default: begin
          r_state <= S_INIT;
          r_ptr   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- stats
`ifdef BP_STATS_EN
  logic [31:0] r_lookup_cnt;
  logic [31:0] r_mispredict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lookup_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_train) begin
      if (r_lookup_cnt != '1) r_lookup_cnt <= r_lookup_cnt + 1'b1;
      if (!predict_resultE && (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
    end
  end

  assign lookup_cnt     = r_lookup_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

  logic w_unused_bits;
  assign w_unused_bits = ^{pcF[31:PHT_INDEX_BITS+2], pcF[1:0]};
`else
  assign lookup_cnt     = '0;
  assign mispredict_cnt = '0;

  logic w_unused_bits;
  assign w_unused_bits = ^{pcF[31:PHT_INDEX_BITS+2], pcF[1:0], predict_resultE};
`endif

endmodule

// File: tb/tb_branch_predict_gshare.sv
// Directed testbench for branch_predict_gshare. Three instances share clk/rst:
//   a: 16-entry bimodal table (initialisation timing)
//   b: 32-entry bimodal table (training, collisions, flush, stats)
//   g: 1024-entry gshare table, 10-bit history (index hashing, GHR flush)
module tb_branch_predict_gshare;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // instance a
  logic [31:0] a_pc;
  logic        a_pred, a_ready, a_br, a_tk, a_res, a_fl;
  logic [3:0]  a_idxF, a_idxE;
  logic [31:0] a_lc, a_mc;

  // instance b
  logic [31:0] b_pc;
  logic        b_pred, b_ready, b_br, b_tk, b_res, b_fl;
  logic [4:0]  b_idxF, b_idxE;
  logic [31:0] b_lc, b_mc;

  // instance g
  logic [31:0] g_pc;
  logic        g_pred, g_ready, g_br, g_tk, g_res, g_fl;
  logic [9:0]  g_idxF, g_idxE;
  logic [31:0] g_lc, g_mc;

  branch_predict_gshare #(.PHT_INDEX_BITS(4), .HIST_BITS(4), .CTR_BITS(2), .INDEX_MODE(0)) u_a (
    .clk(clk), .rst(rst), .pcF(a_pc), .predict_takeF(a_pred), .PHT_indexF(a_idxF),
    .readyF(a_ready), .branchE(a_br), .PHT_indexE(a_idxE), .actually_takenE(a_tk),
    .predict_resultE(a_res), .flush_tbl(a_fl), .lookup_cnt(a_lc), .mispredict_cnt(a_mc));

  branch_predict_gshare #(.PHT_INDEX_BITS(5), .HIST_BITS(5), .CTR_BITS(2), .INDEX_MODE(0)) u_b (
    .clk(clk), .rst(rst), .pcF(b_pc), .predict_takeF(b_pred), .PHT_indexF(b_idxF),
    .readyF(b_ready), .branchE(b_br), .PHT_indexE(b_idxE), .actually_takenE(b_tk),
    .predict_resultE(b_res), .flush_tbl(b_fl), .lookup_cnt(b_lc), .mispredict_cnt(b_mc));

  branch_predict_gshare #(.PHT_INDEX_BITS(10), .HIST_BITS(10), .CTR_BITS(2), .INDEX_MODE(1)) u_g (
    .clk(clk), .rst(rst), .pcF(g_pc), .predict_takeF(g_pred), .PHT_indexF(g_idxF),
    .readyF(g_ready), .branchE(g_br), .PHT_indexE(g_idxE), .actually_takenE(g_tk),
    .predict_resultE(g_res), .flush_tbl(g_fl), .lookup_cnt(g_lc), .mispredict_cnt(g_mc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_pc = 32'h0;  a_br = 0; a_tk = 0; a_res = 0; a_fl = 0; a_idxE = '0;
    b_pc = 32'h40; b_br = 0; b_tk = 0; b_res = 0; b_fl = 0; b_idxE = 5'h10;
    g_pc = 32'h18; g_br = 0; g_tk = 0; g_res = 0; g_fl = 0; g_idxE = '0;
    #2;
    // reset state
    chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
    chk("rst_b_pred",  {31'b0, b_pred},  32'd0);
    chk("rst_b_idxF",  {27'b0, b_idxF},  32'h10);
    chk("rst_g_idxF",  {22'b0, g_idxF},  32'h006);
    chk("rst_b_lc",    b_lc,             32'd0);
    chk("rst_b_mc",    b_mc,             32'd0);
    step();
    step();
    rst = 1'b0;

    // 1. initialisation: a ready after 16 edges, b after 32
    for (int c = 0; c < 32; c++) begin
      if (c < 16) begin
        chk("init_a_ready", {31'b0, a_ready}, 32'd0);
        chk("init_a_pred",  {31'b0, a_pred},  32'd0);
      end
      chk("init_b_ready", {31'b0, b_ready}, 32'd0);
      step();
      if (c == 15) chk("init_a_ready16", {31'b0, a_ready}, 32'd1);
    end
    chk("init_b_ready32", {31'b0, b_ready}, 32'd1);
    chk("init_b_pred40", {31'b0, b_pred}, 32'd0);
    begin
      logic [31:0] pcs [4];
      pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h3c; pcs[3] = 32'h1234;
      for (int i = 0; i < 4; i++) begin
        a_pc = pcs[i];
        #1;
        chk("init_a_wnt", {31'b0, a_pred}, 32'd0);
      end
    end

    // 2. bimodal training on index 0x10
    b_br = 1; b_tk = 1; b_res = 1; b_idxE = 5'h10;
    step(); chk("bim_t1", {31'b0, b_pred}, 32'd1);  // ctr 2
    step(); chk("bim_t2", {31'b0, b_pred}, 32'd1);  // ctr 3
    step(); chk("bim_t3", {31'b0, b_pred}, 32'd1);  // ctr 3 (saturated)
    b_tk = 0;
    step(); chk("bim_n1", {31'b0, b_pred}, 32'd1);  // ctr 2
    step(); chk("bim_n2", {31'b0, b_pred}, 32'd0);  // ctr 1
    b_br = 0;

    // 5b. same-index lookup and update: old MSB now, new MSB next cycle
    b_br = 1; b_tk = 1;
    #1;
    chk("coll_old", {31'b0, b_pred}, 32'd0);
    step();
    b_br = 0;
    #1;
    chk("coll_new", {31'b0, b_pred}, 32'd1);        // ctr 2

    // 4. train to 3, then flush together with a branch (flush wins)
    b_br = 1; b_tk = 1;
    step(); chk("fl_pre", {31'b0, b_pred}, 32'd1);  // ctr 3
    b_fl = 1;
    step();
    b_fl = 0; b_br = 0;
    #1;
    chk("fl_ready0", {31'b0, b_ready}, 32'd0);
    chk("fl_pred0",  {31'b0, b_pred},  32'd0);
    for (int k = 1; k <= 32; k++) begin
      // branches late in INIT target an entry already rewritten
      b_br = (k >= 20 && k <= 30);
      b_tk = 1;
      step();
      b_br = 0;
      chk("fl_ready", {31'b0, b_ready}, (k == 32) ? 32'd1 : 32'd0);
    end
    #1;
    chk("fl_pred_after", {31'b0, b_pred}, 32'd0);

    // 3. gshare index hashing
    for (int i = 0; i < 2000 && !g_ready; i++) step();
    chk("gsh_ready", {31'b0, g_ready}, 32'd1);
    g_br = 1; g_tk = 1; g_idxE = 10'h000; g_pc = 32'h0;
    step();
    chk("gsh_ghr1", {22'b0, g_idxF}, 32'h001);
    step();
    g_tk = 0;
    step();
    g_br = 0;
    #1;
    chk("gsh_pc0",  {22'b0, g_idxF}, 32'h006);
    g_pc = 32'h18;
    #1;
    chk("gsh_pc18", {22'b0, g_idxF}, 32'h000);
    chk("gsh_pred", {31'b0, g_pred}, 32'd1);        // ctr 1->2->3->2
    g_fl = 1;
    step();
    g_fl = 0; g_pc = 32'h0;
    #1;
    chk("gsh_fl_ready", {31'b0, g_ready}, 32'd0);
    chk("gsh_fl_ghr",   {22'b0, g_idxF},  32'h000);

    // 6. stats
    rst = 1'b1;
    step();
    rst = 1'b0;
    b_idxE = 5'h03; b_tk = 0; b_res = 0;
    for (int k = 0; k < 32; k++) begin
      b_br = 1;                                     // ignored during INIT
      step();
    end
    b_br = 0;
    #1;
    chk("st_ready",   {31'b0, b_ready}, 32'd1);
    chk("st_init_lc", b_lc, 32'd0);
    chk("st_init_mc", b_mc, 32'd0);
    b_br = 1;
    b_res = 1; step();
    b_res = 0; step();
    b_res = 1; step();
    b_br = 0;
    #1;
    chk("st_lc3", b_lc, STATS ? 32'd3 : 32'd0);
    chk("st_mc1", b_mc, STATS ? 32'd1 : 32'd0);
    b_fl = 1;
    step();
    b_fl = 0;
    #1;
    chk("st_fl_lc", b_lc, STATS ? 32'd3 : 32'd0);
    chk("st_fl_mc", b_mc, STATS ? 32'd1 : 32'd0);
    rst = 1'b1;
    #1;
    chk("st_rst_lc", b_lc, 32'd0);
    chk("st_rst_mc", b_mc, 32'd0);
    chk("st_rst_ready", {31'b0, b_ready}, 32'd0);
    step();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_gshare.md
# branch_predict_gshare

Parametrised successor to the global branch predictor in the MIPS 5-stage pipeline. Indexes a pattern history table (PHT) of saturating counters from the fetch PC, optionally XOR-hashed with a non-speculative global history register (GHR). Produces a same-cycle taken prediction in F and trains on branches resolved in E. Adds:
- configurable counter width and index mode;
- a sequenced table-initialisation FSM, so the PHT array needs no reset flops;
- a flush command;
- optional performance counters.

## Interface
Parameters:
- PHT_INDEX_BITS, 10, log2 of PHT entries.
- HIST_BITS, 10, GHR length; legal range 1..PHT_INDEX_BITS.
- CTR_BITS, 2, counter width; legal range 2..4.
- INDEX_MODE, 1, selects the index function: 0 = bimodal (PC only), 1 = gshare (PC XOR GHR).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- pcF  in  32  fetch PC.
- predict_takeF  out  1  predicted taken for pcF.
- PHT_indexF  out  PHT_INDEX_BITS  index used for pcF; carried down the pipe to E.
- readyF  out  1  table initialised; predictions valid.
- branchE  in  1  resolved conditional branch in E this cycle.
- PHT_indexE  in  PHT_INDEX_BITS  index captured at fetch for that branch.
- actually_takenE  in  1  branch outcome.
- predict_resultE  in  1  1 = prediction was correct.
- flush_tbl  in  1  single-cycle request to re-initialise PHT and GHR.
- lookup_cnt  out  32  count of resolved branches.
- mispredict_cnt  out  32  count of mispredictions.

## Operation
Index computation:
- pc_hash = pcF[PHT_INDEX_BITS+1:2].
- Mode 0: index = pc_hash.
- Mode 1: index = pc_hash XOR GHR, with the GHR zero-extended to PHT_INDEX_BITS.

Prediction:
- predict_takeF = readyF AND MSB of PHT[PHT_indexF].
- Purely combinational from pcF and the GHR.

FSM states are INIT and READY.
- Reset: enter INIT, ptr=0, GHR=0.
- INIT:
  - Each cycle writes WNT = 2^(CTR_BITS-1)-1 to PHT[ptr], then increments ptr.
  - After writing entry 2^PHT_INDEX_BITS-1, go to READY.
  - readyF=0 throughout INIT.
- READY: readyF=1; training is enabled.
- flush_tbl in READY: go to INIT with ptr=0 and GHR=0.
- flush_tbl in INIT: restart with ptr=0.

Training, when branchE and READY:
- Counter update:
  - If actually_takenE, PHT[PHT_indexE] increments, saturating at 2^CTR_BITS-1.
  - Otherwise it decrements, saturating at 0.
- GHR update: GHR <= {GHR[HIST_BITS-2:0], actually_takenE}. For HIST_BITS=1, GHR <= actually_takenE.

Ignored inputs:
- branchE during INIT is ignored: no counter write, no GHR shift, no stats update.
- predict_resultE is ignored for training and feeds the stats only.

Same-cycle read/write to the same index:
- The lookup returns the pre-update value.
- The write lands at the clock edge.

## Timing
- Reset values: predict_takeF=0, readyF=0, PHT_indexF=pc_hash (GHR=0), lookup_cnt=0, mispredict_cnt=0.
- The PHT contents are undefined until INIT completes, which is masked by readyF.
- Prediction latency: 0 cycles, combinational.
- Training latency: the counter and GHR update at the edge ending the branchE cycle and are visible to lookups in the following cycle.
- INIT duration: exactly 2^PHT_INDEX_BITS cycles. readyF rises on the 2^PHT_INDEX_BITS-th rising edge after rst deasserts, or after the edge that samples flush_tbl.
- rst asserted mid-INIT or mid-READY: immediately return to INIT with ptr=0. Counters clear asynchronously.
- flush_tbl with branchE in the same cycle: the flush wins and the update is dropped.

## Configuration
Macro BP_STATS_EN.
- Defined:
  - lookup_cnt increments on each branchE in READY.
  - mispredict_cnt increments on each branchE AND NOT predict_resultE in READY.
  - Both counters saturate at 0xFFFFFFFF.
  - Both are cleared by rst only, not by flush_tbl.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

## Test plan
1. **Initialisation.** PHT_INDEX_BITS=4, release rst.
   - Required: readyF=0 and predict_takeF=0 for 16 cycles; readyF=1 from cycle 16.
   - Required: predict_takeF=0 for any pcF after that (WNT=1).
2. **Bimodal training.** INDEX_MODE=0, CTR_BITS=2, pcF=0x40 (index 0x10).
   - branchE taken, one per cycle, three times: predict_takeF reads 1 after the first; the counter saturates at 3.
   - Then not-taken twice: predict_takeF stays 1 after the first (ctr=2) and reads 0 after the second (ctr=1).
3. **Gshare index.** INDEX_MODE=1, HIST_BITS=10.
   - Resolve taken, taken, not-taken: GHR=0b110.
   - pcF=0x0 gives PHT_indexF=0x006; pcF=0x18 (pc_hash 0x006) gives PHT_indexF=0x000.
4. **Flush mid-operation.** Train index 0x10 to 3, pulse flush_tbl.
   - Required: readyF=0 the next cycle; GHR=0.
   - Required: after 2^PHT_INDEX_BITS cycles, predict_takeF for pcF=0x40 reads 0.
   - A branchE issued during INIT leaves no trace.
5. **Collisions.**
   - branchE and flush_tbl in the same cycle: the update is dropped.
   - Same-index lookup and update in one cycle: the lookup returns the old MSB and the new MSB appears next cycle.
6. **Stats, with BP_STATS_EN.** Three branchE, one with predict_resultE=0.
   - Required: lookup_cnt=3, mispredict_cnt=1.
   - After flush_tbl both counts are unchanged; after rst both are 0.
   - Without the macro, both outputs read 0 throughout.
